// File: rtl/dec8b10b_pkg.sv
// Shared constants, types and the sub-block disparity classifier for the 10b->8b decoder.
package dec8b10b_pkg;

  localparam logic RDM = 1'b0;
  localparam logic RDP = 1'b1;

  localparam logic [5:0] K28_6B_N = 6'b001111;
  localparam logic [5:0] K28_6B_P = 6'b110000;
  localparam logic [5:0] D7_6B_N  = 6'b111000;
  localparam logic [5:0] D7_6B_P  = 6'b000111;
  localparam logic [3:0] A7_4B_N  = 4'b0111;
  localparam logic [3:0] A7_4B_P  = 4'b1000;

  typedef enum logic [1:0] {NEG, NEU, POS, BAD} disp_e;
  typedef enum logic {ST_RDM = RDM, ST_RDP = RDP} rd_state_e;

  // Classifies a 6b sub-block (is_6b=1) or the 4b sub-block held in bits[3:0].
  function automatic disp_e subblk_disp(input logic [5:0] bits, input logic is_6b);
    logic [2:0] ones;
    disp_e      cls;
    ones = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (is_6b || i < 4) ones = ones + {2'b00, bits[i]};
    end
    cls = BAD;
    if (is_6b) begin
      case (ones)
        3'd2:    cls = NEG;
        3'd3:    cls = (bits == D7_6B_P) ? POS : (bits == D7_6B_N) ? NEG : NEU;
        3'd4:    cls = POS;
        default: cls = BAD;
      endcase
    end else begin
      case (ones)
        3'd1:    cls = NEG;
        3'd2:    cls = (bits[3:0] == 4'b0011) ? POS : (bits[3:0] == 4'b1100) ? NEG : NEU;
        3'd3:    cls = POS;
        default: cls = BAD;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/dec_subblock_lut.sv
// Combinational 6b->5b / 4b->3b decode tables with K-candidate and disparity classification.
module dec_subblock_lut
  import dec8b10b_pkg::*;
(
  input  logic [9:0] sym,
  output logic [4:0] dec5,
  output logic       valid6,
  output logic [2:0] dec3,
  output logic       valid4,
  output logic       k28,
  output logic       a7_n,
  output logic       a7_p,
  output disp_e      cls6,
  output disp_e      cls4
);

  logic [5:0] abcdei;
  logic [3:0] fghj;
  logic [3:0] fghj_eff;

  always_comb begin
    abcdei   = sym[9:4];
    fghj     = sym[3:0];
    k28      = (abcdei == K28_6B_N) || (abcdei == K28_6B_P);
    // After 110000 the K28 balanced 4b codes are sent complemented; fold them back.
    fghj_eff = (abcdei == K28_6B_P) ? ~fghj : fghj;
    a7_n     = (fghj_eff == A7_4B_N);
    a7_p     = (fghj_eff == A7_4B_P);
    cls6     = subblk_disp(abcdei, 1'b1);
    cls4     = subblk_disp({2'b00, fghj}, 1'b0);

    dec5   = 5'd0;
    valid6 = 1'b1;
    case (abcdei)
      6'b100111, 6'b011000:             dec5 = 5'd0;
      6'b011101, 6'b100010:             dec5 = 5'd1;
      6'b101101, 6'b010010:             dec5 = 5'd2;
      6'b110001:                        dec5 = 5'd3;
      6'b110101, 6'b001010:             dec5 = 5'd4;
      6'b101001:                        dec5 = 5'd5;
      6'b011001:                        dec5 = 5'd6;
      6'b111000, 6'b000111:             dec5 = 5'd7;
      6'b111001, 6'b000110:             dec5 = 5'd8;
      6'b100101:                        dec5 = 5'd9;
      6'b010101:                        dec5 = 5'd10;
      6'b110100:                        dec5 = 5'd11;
      6'b001101:                        dec5 = 5'd12;
      6'b101100:                        dec5 = 5'd13;
      6'b011100:                        dec5 = 5'd14;
      6'b010111, 6'b101000:             dec5 = 5'd15;
      6'b011011, 6'b100100:             dec5 = 5'd16;
      6'b100011:                        dec5 = 5'd17;
      6'b010011:                        dec5 = 5'd18;
      6'b110010:                        dec5 = 5'd19;
      6'b001011:                        dec5 = 5'd20;
      6'b101010:                        dec5 = 5'd21;
      6'b011010:                        dec5 = 5'd22;
      6'b111010, 6'b000101:             dec5 = 5'd23;
      6'b110011, 6'b001100:             dec5 = 5'd24;
      6'b100110:                        dec5 = 5'd25;
      6'b010110:                        dec5 = 5'd26;
      6'b110110, 6'b001001:             dec5 = 5'd27;
      6'b001110, 6'b001111, 6'b110000:  dec5 = 5'd28;
      6'b101110, 6'b010001:             dec5 = 5'd29;
      6'b011110, 6'b100001:             dec5 = 5'd30;
      6'b101011, 6'b010100:             dec5 = 5'd31;
      default:                          valid6 = 1'b0;
    endcase

    dec3   = 3'd0;
    valid4 = 1'b1;
    case (fghj_eff)
      4'b1011, 4'b0100:                    dec3 = 3'd0;
      4'b1001:                             dec3 = 3'd1;
      4'b0101:                             dec3 = 3'd2;
      4'b1100, 4'b0011:                    dec3 = 3'd3;
      4'b1101, 4'b0010:                    dec3 = 3'd4;
      4'b1010:                             dec3 = 3'd5;
      4'b0110:                             dec3 = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000:  dec3 = 3'd7;
      default:                             valid4 = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_10b8b.sv
// 8b/10b receive decoder with running-disparity tracking and error flags, latency 1.
// Define DEC_ERRCNT_EN to add the saturating errcnt output (width ERRCNT_W).
module decode_10b8b
  import dec8b10b_pkg::*;
#(
  parameter bit INIT_RD = 1'b0
`ifdef DEC_ERRCNT_EN
  ,
  parameter int ERRCNT_W = 8
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startin,
  input  logic       pushin,
  input  logic [9:0] datain,
  output logic       pushout,
  output logic [7:0] dataout,
  output logic       kout,
  output logic       rdout,
  output logic       disperr,
  output logic       codeerr
`ifdef DEC_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] errcnt
`endif
);

  localparam rd_state_e RD_INIT = rd_state_e'(INIT_RD);

  logic [4:0] dec5;
  logic [2:0] dec3;
  logic       valid6, valid4, k28, a7_n, a7_p;
  disp_e      cls6, cls4;

  rd_state_e  rd_q, rd_d, rd6, rd_after;
  logic       dperr6, dperr4, k_alt, k_sym, a7_bad, code_bad, accept;

  dec_subblock_lut u_lut (
    .sym   (datain),
    .dec5  (dec5),
    .valid6(valid6),
    .dec3  (dec3),
    .valid4(valid4),
    .k28   (k28),
    .a7_n  (a7_n),
    .a7_p  (a7_p),
    .cls6  (cls6),
    .cls4  (cls4)
  );

  always_comb begin
    rd6      = rd_q;
    dperr6   = 1'b0;
    rd_after = rd_q;
    dperr4   = 1'b0;
    case (cls6)
      POS:     begin rd6 = ST_RDP; dperr6 = (rd_q == ST_RDP); end
      NEG:     begin rd6 = ST_RDM; dperr6 = (rd_q == ST_RDM); end
      default: rd6 = rd_q;
    endcase
    rd_after = rd6;
    case (cls4)
      POS:     begin rd_after = ST_RDP; dperr4 = (rd6 == ST_RDP); end
      NEG:     begin rd_after = ST_RDM; dperr4 = (rd6 == ST_RDM); end
      default: rd_after = rd6;
    endcase

    // K23/27/29/30.7 need the A7 form that matches the RD left by their 6b code.
    k_alt    = ((a7_p && cls6 == POS) || (a7_n && cls6 == NEG)) &&
               (dec5 inside {5'd23, 5'd27, 5'd29, 5'd30});
    k_sym    = k28 || k_alt;
    a7_bad   = !k_sym && ((a7_n && !(dec5 inside {5'd17, 5'd18, 5'd20})) ||
                          (a7_p && !(dec5 inside {5'd11, 5'd13, 5'd14})));
    code_bad = !valid6 || !valid4 || a7_bad;

    accept = pushin && !startin;
    rd_d   = rd_q;
    if (startin)     rd_d = RD_INIT;
    else if (pushin) rd_d = rd_after;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q    <= RD_INIT;
      pushout <= 1'b0;
      dataout <= 8'h00;
      kout    <= 1'b0;
      disperr <= 1'b0;
      codeerr <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      pushout <= accept;
      if (accept) begin
        dataout <= code_bad ? 8'h00 : {dec3, dec5};
        kout    <= k_sym && !code_bad;
        disperr <= dperr6 || dperr4;
        codeerr <= code_bad;
      end
    end
  end

  assign rdout = rd_q;

`ifdef DEC_ERRCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errcnt <= '0;
    end else if (startin) begin
      errcnt <= '0;
    end else if (accept && (dperr6 || dperr4 || code_bad) && (errcnt != '1)) begin
      errcnt <= errcnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_10b8b.sv
// Directed bench for decode_10b8b: K28.5 both RDs, data, disparity/code errors, A7, startin, streaming.
module tb_decode_10b8b;

  logic       clk, reset, startin, pushin;
  logic [9:0] datain;
  logic       pushout, kout, rdout, disperr, codeerr;
  logic [7:0] dataout;
`ifdef DEC_ERRCNT_EN
  logic [7:0] errcnt;
`endif

  int errors = 0;
  int checks = 0;

  // Observed bundle: {pushout, dataout, kout, rdout, disperr, codeerr}
  logic [12:0] obs;
  logic [12:0] exp_v;
  assign obs = {pushout, dataout, kout, rdout, disperr, codeerr};

  decode_10b8b dut (
    .clk    (clk),
    .reset  (reset),
    .startin(startin),
    .pushin (pushin),
    .datain (datain),
    .pushout(pushout),
    .dataout(dataout),
    .kout   (kout),
    .rdout  (rdout),
    .disperr(disperr),
    .codeerr(codeerr)
`ifdef DEC_ERRCNT_EN
    ,
    .errcnt (errcnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one symbol for one cycle; returns on the negedge after capture.
  task automatic send(input logic [9:0] s);
    @(negedge clk);
    pushin = 1'b1;
    datain = s;
    @(negedge clk);
    pushin = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; startin = 1'b0; pushin = 1'b0; datain = 10'h000;
    repeat (2) @(negedge clk);
    exp_v = 13'h0;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs, exp_v); end
    checks++;
    reset = 1'b0;
    @(negedge clk);
    if (obs !== exp_v) begin errors++; $display("FAIL reset_release: got %h expected %h", obs, exp_v); end
    checks++;
  endtask

  task automatic test_k28;
    send(10'h0FA);
    exp_v = {1'b1, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL k28_5_minus: got %h expected %h", obs, exp_v); end
    checks++;
    send(10'h305);
    exp_v = {1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL k28_5_plus: got %h expected %h", obs, exp_v); end
    checks++;
    send(10'h2AA);
    exp_v = {1'b1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL d21_5: got %h expected %h", obs, exp_v); end
    checks++;
    @(negedge clk);
    exp_v = {1'b0, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL idle_hold: got %h expected %h", obs, exp_v); end
    checks++;
  endtask

  task automatic test_disperr;
    send(10'h305);
    exp_v = {1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL disperr_k28: got %h expected %h", obs, exp_v); end
    checks++;
  endtask

  task automatic test_codeerr;
    send(10'h000);
    exp_v = {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    if (obs !== exp_v) begin errors++; $display("FAIL codeerr_zero: got %h expected %h", obs, exp_v); end
    checks++;
  endtask

  task automatic test_alt7;
    send(10'h237);  // D17.A7 at RD-
    exp_v = {1'b1, 8'hF1, 1'b0, 1'b1, 1'b0, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL d17_a7: got %h expected %h", obs, exp_v); end
    checks++;
    send(10'h057);  // K23.7 at RD+
    exp_v = {1'b1, 8'hF7, 1'b1, 1'b1, 1'b0, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL k23_7: got %h expected %h", obs, exp_v); end
    checks++;
    send(10'h227);  // D1 with A7 is not a legal combination
    exp_v = {1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    if (obs !== exp_v) begin errors++; $display("FAIL d1_a7_illegal: got %h expected %h", obs, exp_v); end
    checks++;
  endtask

  task automatic test_startin;
    @(negedge clk);
    startin = 1'b1;
    @(negedge clk);
    startin = 1'b0;
    exp_v = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    if (obs !== exp_v) begin errors++; $display("FAIL startin_alone: got %h expected %h", obs, exp_v); end
    checks++;
    send(10'h0FA);
    exp_v = {1'b1, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL startin_pre: got %h expected %h", obs, exp_v); end
    checks++;
    startin = 1'b1; pushin = 1'b1; datain = 10'h305;
    @(negedge clk);
    startin = 1'b0; pushin = 1'b0;
    exp_v = {1'b0, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL startin_priority: got %h expected %h", obs, exp_v); end
    checks++;
    send(10'h0FA);
    exp_v = {1'b1, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL startin_post: got %h expected %h", obs, exp_v); end
    checks++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    startin = 1'b1;
    @(negedge clk);
    startin = 1'b0;
    pushin  = 1'b1;
    datain  = 10'h0FA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_v = {1'b1, 8'hBC, 1'b1, ((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0};
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL b2b_%0d: got %h expected %h", i, obs, exp_v);
      end
      checks++;
      if (i < 9) datain = ((i % 2) == 0) ? 10'h305 : 10'h0FA;
      else       pushin = 1'b0;
    end
    @(negedge clk);
    if (pushout !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", pushout); end
    checks++;
  endtask

  task automatic test_reset_mid;
    send(10'h0FA);
    exp_v = {1'b1, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL mid_pre: got %h expected %h", obs, exp_v); end
    checks++;
    #2 reset = 1'b1;
    #1;
    exp_v = 13'h0;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_async_reset: got %h expected %h", obs, exp_v); end
    checks++;
    @(negedge clk);
    reset = 1'b0;
  endtask

`ifdef DEC_ERRCNT_EN
  task automatic test_errcnt;
    @(negedge clk);
    startin = 1'b1;
    @(negedge clk);
    startin = 1'b0;
    if (errcnt !== 8'h00) begin errors++; $display("FAIL errcnt_clear: got %h expected 00", errcnt); end
    checks++;
    send(10'h000);
    if (errcnt !== 8'h01) begin errors++; $display("FAIL errcnt_one: got %h expected 01", errcnt); end
    checks++;
    pushin = 1'b1;
    datain = 10'h000;
    repeat (300) @(negedge clk);
    pushin = 1'b0;
    @(negedge clk);
    if (errcnt !== 8'hFF) begin errors++; $display("FAIL errcnt_sat: got %h expected ff", errcnt); end
    checks++;
  endtask
`endif

  initial begin
    test_reset();
    test_k28();
    test_disperr();
    test_codeerr();
    test_alt7();
    test_startin();
    test_back_to_back();
    test_reset_mid();
`ifdef DEC_ERRCNT_EN
    test_errcnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
